// File: rtl/alu_ctrl_md.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// The divider (DIV state and restoring datapath) is built only when ALU_CTRL_DIV_EN is defined.
module alu_ctrl_md #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [5:0]        inst,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [3:0]        op,
    output logic              illegal,
    output logic              stall,
    output logic              mf_sel,
    output logic [DATA_W-1:0] mf_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef ALU_CTRL_DIV_EN
        DIV  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg;
    logic [DATA_W-1:0]   acc_reg, mq_reg, opb_reg;
    logic                neg_q_reg;
    logic [DATA_W-1:0]   hi_reg, lo_reg;
    logic [DATA_W-1:0]   hi_next, lo_next;
    logic [DATA_W-1:0]   acc_next, mq_next;

    // ---------------- instruction decode ----------------
    logic is_rtype, is_mult, is_multu, is_mfhi, is_mflo, md_cand, op_signed;
    logic [3:0] op_dec;
    logic       legal;

    assign is_rtype = (alu_op == 2'b10);
    assign is_mult  = is_rtype & (funct == 6'b011000);
    assign is_multu = is_rtype & (funct == 6'b011001);
    assign is_mfhi  = is_rtype & (funct == 6'b010000);
    assign is_mflo  = is_rtype & (funct == 6'b010010);

`ifdef ALU_CTRL_DIV_EN
    logic is_div, is_divu;
    assign is_div    = is_rtype & (funct == 6'b011010);
    assign is_divu   = is_rtype & (funct == 6'b011011);
    assign md_cand   = is_mult | is_multu | is_div | is_divu;
    assign op_signed = is_mult | is_div;
`else
    assign md_cand   = is_mult | is_multu;
    assign op_signed = is_mult;
`endif

    always_comb begin
        op_dec = 4'b0010;
        legal  = 1'b0;
        case (alu_op)
            2'b00: legal = 1'b1;
            2'b01: begin
                case (inst)
                    6'b000100: begin op_dec = 4'b0110; legal = 1'b1; end
                    6'b000101: begin op_dec = 4'b0101; legal = 1'b1; end
                    default: ;
                endcase
            end
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: begin op_dec = 4'b0010; legal = 1'b1; end
                    6'b100010, 6'b100011: begin op_dec = 4'b0110; legal = 1'b1; end
                    6'b100100: begin op_dec = 4'b0000; legal = 1'b1; end
                    6'b100101: begin op_dec = 4'b0001; legal = 1'b1; end
                    6'b100110: begin op_dec = 4'b0011; legal = 1'b1; end
                    6'b100111: begin op_dec = 4'b1100; legal = 1'b1; end
                    6'b101010: begin op_dec = 4'b0111; legal = 1'b1; end
                    6'b101011: begin op_dec = 4'b1000; legal = 1'b1; end
                    6'b000000: begin op_dec = 4'b1001; legal = 1'b1; end
                    6'b000010: begin op_dec = 4'b1010; legal = 1'b1; end
                    6'b000011: begin op_dec = 4'b1011; legal = 1'b1; end
                    6'b011000, 6'b011001, 6'b010000, 6'b010010: legal = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                    6'b011010, 6'b011011: legal = 1'b1;
`endif
                    default: ;
                endcase
            end
            2'b11: begin
                case (inst)
                    6'b001000, 6'b001001: begin op_dec = 4'b0010; legal = 1'b1; end
                    6'b001100: begin op_dec = 4'b0000; legal = 1'b1; end
                    6'b001101: begin op_dec = 4'b0001; legal = 1'b1; end
                    6'b001110: begin op_dec = 4'b0011; legal = 1'b1; end
                    6'b001010: begin op_dec = 4'b0111; legal = 1'b1; end
                    6'b001011: begin op_dec = 4'b1000; legal = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign op      = op_dec;
    assign illegal = valid_in & ~legal;
    assign mf_sel  = valid_in & (is_mfhi | is_mflo);
    assign mf_data = is_mfhi ? hi_reg : lo_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;

    // ---------------- control ----------------
    logic start, busy, last;

    // rst_n gates start so stall drops the moment reset asserts
    assign start = rst_n & valid_in & ~flush & (state_reg == IDLE) & md_cand;
`ifdef ALU_CTRL_DIV_EN
    assign busy  = (state_reg == MUL) | (state_reg == DIV);
`else
    assign busy  = (state_reg == MUL);
`endif
    assign stall = (start | busy) & ~flush;
    assign last  = (count_reg == CNT_W'(DATA_W - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef ALU_CTRL_DIV_EN
                    state_next = (is_div | is_divu) ? DIV : MUL;
`else
                    state_next = MUL;
`endif
                end
            end
            MUL:  if (last) state_next = DONE;
`ifdef ALU_CTRL_DIV_EN
            DIV:  if (last) state_next = DONE;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // ---------------- operand preparation ----------------
    logic              rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_mag, rt_mag;

    assign rs_neg = op_signed & rs_data[DATA_W-1];
    assign rt_neg = op_signed & rt_data[DATA_W-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    // ---------------- shift-add multiplier step ----------------
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_acc, mul_mq;
    logic [2*DATA_W-1:0] mul_prod, mul_res;

    assign mul_sum  = {1'b0, acc_reg} + ({1'b0, opb_reg} & {(DATA_W+1){mq_reg[0]}});
    assign mul_acc  = mul_sum[DATA_W:1];
    assign mul_mq   = {mul_sum[0], mq_reg[DATA_W-1:1]};
    assign mul_prod = {mul_acc, mul_mq};
    assign mul_res  = neg_q_reg ? -mul_prod : mul_prod;

`ifdef ALU_CTRL_DIV_EN
    // ---------------- restoring divider step ----------------
    logic              neg_r_reg, div_zero_reg;
    logic [DATA_W-1:0] dividend_reg;
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem, div_quo, div_q_fin, div_r_fin;

    assign div_shift = {acc_reg, mq_reg[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_reg});
    // remainder stays below the divisor, so the low bits of the difference are exact
    assign div_rem   = div_ge ? (div_shift[DATA_W-1:0] - opb_reg) : div_shift[DATA_W-1:0];
    assign div_quo   = {mq_reg[DATA_W-2:0], div_ge};
    assign div_q_fin = neg_q_reg ? -div_quo : div_quo;
    assign div_r_fin = neg_r_reg ? -div_rem : div_rem;
`endif

    always_comb begin
        acc_next = mul_acc;
        mq_next  = mul_mq;
        hi_next  = mul_res[2*DATA_W-1:DATA_W];
        lo_next  = mul_res[DATA_W-1:0];
`ifdef ALU_CTRL_DIV_EN
        if (state_reg == DIV) begin
            acc_next = div_rem;
            mq_next  = div_quo;
            if (div_zero_reg) begin
                hi_next = dividend_reg;
                lo_next = '1;
            end else begin
                hi_next = div_r_fin;
                lo_next = div_q_fin;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            acc_reg   <= '0;
            mq_reg    <= '0;
            opb_reg   <= '0;
            neg_q_reg <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else if (start) begin
            count_reg <= '0;
            acc_reg   <= '0;
            mq_reg    <= rs_mag;
            opb_reg   <= rt_mag;
            neg_q_reg <= rs_neg ^ rt_neg;
        end else if (busy) begin
            count_reg <= count_reg + CNT_W'(1);
            acc_reg   <= acc_next;
            mq_reg    <= mq_next;
            if (last && !flush) begin
                hi_reg <= hi_next;
                lo_reg <= lo_next;
            end
        end
    end

`ifdef ALU_CTRL_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            dividend_reg <= '0;
        end else if (start) begin
            neg_r_reg    <= rs_neg;
            div_zero_reg <= (rt_data == '0);
            dividend_reg <= rs_data;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Self-checking bench for alu_ctrl_md: decode table, mult/div scoreboard, reset and flush aborts.
module tb_alu_ctrl_md;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    alu_op;
    logic [5:0]    funct, inst;
    logic          valid_in, flush;
    logic [W-1:0]  rs_data, rt_data;
    logic [3:0]    op;
    logic          illegal, stall, mf_sel;
    logic [W-1:0]  mf_data, hi, lo;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] sb_q[$];
    logic [W-1:0]   last_hi = '0, last_lo = '0;

    alu_ctrl_md #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .inst(inst),
        .valid_in(valid_in), .flush(flush), .rs_data(rs_data), .rt_data(rt_data),
        .op(op), .illegal(illegal), .stall(stall), .mf_sel(mf_sel),
        .mf_data(mf_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic dec_chk(input logic [1:0] a, input logic [5:0] f, input logic [5:0] i,
                           input logic [3:0] exp_op, input logic exp_ill);
        @(negedge clk);
        alu_op = a; funct = f; inst = i; valid_in = 1'b1;
        #1;
        $display("decode alu_op=%b funct=%b inst=%b op=%b illegal=%b", a, f, i, op, illegal);
        check_val("dec_op", 64'(op), 64'(exp_op));
        check_val("dec_illegal", 64'(illegal), 64'(exp_ill));
        valid_in = 1'b0;
    endtask

    // issue a mult/div, hold it in EX while stalled, then score the HI/LO result
    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_hl);
        int cnt;
        logic [2*W-1:0] e;
        sb_q.push_back(exp_hl);
        @(negedge clk);
        alu_op = 2'b10; funct = f; inst = 6'd0; rs_data = a; rt_data = b; valid_in = 1'b1;
        #1;
        cnt = 0;
        while (stall === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check_val("stall_cycles", 64'(cnt), 64'(W + 1));
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 64'(0), 64'(1));
        end else begin
            e = sb_q.pop_front();
            check_val("hi", 64'(hi), 64'(e[2*W-1:W]));
            check_val("lo", 64'(lo), 64'(e[W-1:0]));
            last_hi = e[2*W-1:W];
            last_lo = e[W-1:0];
        end
        $display("md funct=%b rs=%h rt=%h hi=%h lo=%h stall_cycles=%0d", f, a, b, hi, lo, cnt);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [2*W-1:0] umul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    initial begin
        logic [W-1:0] ra, rb, keep_hi, keep_lo;
        int cnt;
        rst_n = 1'b0; alu_op = 2'b00; funct = '0; inst = '0; valid_in = 1'b0; flush = 1'b0;
        rs_data = '0; rt_data = '0;
        #1;
        check_val("rst_stall", 64'(stall), 64'(0));
        check_val("rst_hi", 64'(hi), 64'(0));
        check_val("rst_lo", 64'(lo), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        dec_chk(2'b00, 6'b000000, 6'b100011, 4'b0010, 1'b0);
        dec_chk(2'b01, 6'b000000, 6'b000100, 4'b0110, 1'b0);
        dec_chk(2'b01, 6'b000000, 6'b000101, 4'b0101, 1'b0);
        dec_chk(2'b01, 6'b000000, 6'b000000, 4'b0010, 1'b1);
        dec_chk(2'b10, 6'b100001, 6'b000000, 4'b0010, 1'b0);
        dec_chk(2'b10, 6'b100010, 6'b000000, 4'b0110, 1'b0);
        dec_chk(2'b10, 6'b100100, 6'b000000, 4'b0000, 1'b0);
        dec_chk(2'b10, 6'b100101, 6'b000000, 4'b0001, 1'b0);
        dec_chk(2'b10, 6'b100110, 6'b000000, 4'b0011, 1'b0);
        dec_chk(2'b10, 6'b100111, 6'b000000, 4'b1100, 1'b0);
        dec_chk(2'b10, 6'b101010, 6'b000000, 4'b0111, 1'b0);
        dec_chk(2'b10, 6'b101011, 6'b000000, 4'b1000, 1'b0);
        dec_chk(2'b10, 6'b000000, 6'b000000, 4'b1001, 1'b0);
        dec_chk(2'b10, 6'b000010, 6'b000000, 4'b1010, 1'b0);
        dec_chk(2'b10, 6'b000011, 6'b000000, 4'b1011, 1'b0);
        dec_chk(2'b10, 6'b111111, 6'b000000, 4'b0010, 1'b1);
        dec_chk(2'b10, 6'b010000, 6'b000000, 4'b0010, 1'b0);
        dec_chk(2'b11, 6'b000000, 6'b001000, 4'b0010, 1'b0);
        dec_chk(2'b11, 6'b000000, 6'b001100, 4'b0000, 1'b0);
        dec_chk(2'b11, 6'b000000, 6'b001101, 4'b0001, 1'b0);
        dec_chk(2'b11, 6'b000000, 6'b001110, 4'b0011, 1'b0);
        dec_chk(2'b11, 6'b000000, 6'b001010, 4'b0111, 1'b0);
        dec_chk(2'b11, 6'b000000, 6'b001011, 4'b1000, 1'b0);
        dec_chk(2'b11, 6'b000000, 6'b111111, 4'b0010, 1'b1);

        // illegal is gated by valid_in
        @(negedge clk);
        alu_op = 2'b11; inst = 6'b111111; valid_in = 1'b0;
        #1;
        check_val("illegal_gated", 64'(illegal), 64'(0));

        run_md(6'b011000, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_md(6'b011001, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
        for (int k = 0; k < 4; k++) begin
            ra = $urandom; rb = $urandom;
            if (k[0]) run_md(6'b011001, ra, rb, umul(ra, rb));
            else      run_md(6'b011000, ra, rb, smul(ra, rb));
        end

        // mflo / mfhi read the registers just written
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b010010; valid_in = 1'b1;
        #1;
        check_val("mflo_sel", 64'(mf_sel), 64'(1));
        check_val("mflo_data", 64'(mf_data), 64'(last_lo));
        funct = 6'b010000;
        #1;
        check_val("mfhi_data", 64'(mf_data), 64'(last_hi));
        valid_in = 1'b0;
        #1;
        check_val("mf_sel_idle", 64'(mf_sel), 64'(0));
        $display("mf hi=%h lo=%h", last_hi, last_lo);

`ifdef ALU_CTRL_DIV_EN
        run_md(6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md(6'b011010, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF);
        run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_md(6'b011011, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E);
`else
        // divider absent: div/divu are illegal and start nothing
        keep_hi = hi; keep_lo = lo;
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b011010; rs_data = 32'd9; rt_data = 32'd2; valid_in = 1'b1;
        #1;
        check_val("nodiv_illegal", 64'(illegal), 64'(1));
        check_val("nodiv_op", 64'(op), 64'(4'b0010));
        check_val("nodiv_stall", 64'(stall), 64'(0));
        funct = 6'b011011;
        #1;
        check_val("nodivu_illegal", 64'(illegal), 64'(1));
        repeat (3) @(negedge clk);
        valid_in = 1'b0;
        #1;
        check_val("nodiv_hi", 64'(hi), 64'(keep_hi));
        check_val("nodiv_lo", 64'(lo), 64'(keep_lo));
        $display("nodiv hi=%h lo=%h", hi, lo);
`endif

        // flush at cycle 10 of a mult: back to IDLE, HI/LO untouched
        run_md(6'b011000, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F);
        keep_hi = hi; keep_lo = lo;
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b011001; rs_data = 32'h1234_5678; rt_data = 32'h0000_1000;
        valid_in = 1'b1;
        repeat (10) @(negedge clk);
        valid_in = 1'b0; flush = 1'b1;
        #1;
        check_val("flush_stall", 64'(stall), 64'(0));
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_val("flush_idle_stall", 64'(stall), 64'(0));
        repeat (40) @(negedge clk);
        #1;
        check_val("flush_hi", 64'(hi), 64'(keep_hi));
        check_val("flush_lo", 64'(lo), 64'(keep_lo));
        $display("flush hi=%h lo=%h", hi, lo);

        // flush together with a start candidate starts nothing
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b011000; valid_in = 1'b1; flush = 1'b1;
        #1;
        check_val("flush_start_stall", 64'(stall), 64'(0));
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        #1;
        check_val("flush_start_idle", 64'(stall), 64'(0));

        // reset at cycle 10 of a mult: stall drops at once, HI/LO cleared, result discarded
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b011000; rs_data = 32'h0000_0011; rt_data = 32'h0000_0013;
        valid_in = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_val("pre_rst_stall", 64'(stall), 64'(1));
        valid_in = 1'b0; rst_n = 1'b0;
        #1;
        check_val("mid_rst_stall", 64'(stall), 64'(0));
        check_val("mid_rst_hi", 64'(hi), 64'(0));
        check_val("mid_rst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (stall === 1'b1) cnt++;
        end
        check_val("post_rst_stall", 64'(cnt), 64'(0));
        check_val("post_rst_lo", 64'(lo), 64'(0));
        $display("reset abort hi=%h lo=%h", hi, lo);

        check_val("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
